// File: rtl/uart_rx_capture_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_capture_pkg
// Shared definitions for the console UART receiver: receiver FSM state
// encodings, the frame data width and a small counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_rx_capture_pkg;

    // Number of data bits in one 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // Width needed to count 0..clks_per_bit-1 (at least 1 bit).
    function automatic int bit_cnt_width(input int clks_per_bit);
        int w;
        w = $clog2(clks_per_bit);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_capture_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_capture_sync_fifo
// Show-ahead register-array FIFO holding received bytes.
// Pointers are AW+1 bits wide so that full and empty are distinguished by the
// extra wrap bit; count = wr_ptr - rd_ptr.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes the FIFO)
//   push_i     : write data_i at the tail
//   data_i     : byte to write
//   pop_i      : remove head byte; ignored while empty
//   data_o     : head byte (0 while empty)
//   empty_o    : FIFO holds no bytes
//   count_o    : number of bytes held
//   drop_o     : push refused because FIFO full and no pop this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_capture_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic             drop_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [AW:0]      count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Occupancy, accept/refuse decisions and next pointer values.
    always_comb begin
        count_s   = wr_ptr_q - rd_ptr_q;
        full_s    = (count_s == FULL_CNT);
        empty_s   = (count_s == {(AW+1){1'b0}});
        pop_ok_s  = pop_i & ~empty_s;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        push_ok_s = push_i & (~full_s | pop_ok_s);
        drop_o    = push_i & full_s & ~pop_ok_s;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (empty_s) begin
            data_o = {WIDTH{1'b0}};
        end else begin
            data_o = mem_q[rd_ptr_q[AW-1:0]];
        end
        empty_o = empty_s;
        count_o = count_s;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// -----------------------------------------------------------------------------
// uart_rx_capture
// 8N1 UART receiver feeding a show-ahead byte FIFO. Samples the asynchronous
// serial line through a 2-FF synchronizer plus edge register, times each bit
// with a counter, assembles bytes LSB first and pushes them into the FIFO.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   uart_rx_i    : serial line, idle high, asynchronous to clk
//   rd_en_i      : pop head byte (ignored when rd_valid_o=0)
//   rd_data_o    : head-of-FIFO byte
//   rd_valid_o   : FIFO not empty
//   fifo_count_o : bytes held
//   frame_err_o  : 1-cycle pulse, stop bit sampled low
//   overrun_o    : 1-cycle pulse, received byte dropped because FIFO full
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_capture
    import uart_rx_capture_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx_i,
    input  logic               rd_en_i,
    output logic [7:0]         rd_data_o,
    output logic               rd_valid_o,
    output logic [FIFO_AW:0]   fifo_count_o,
    output logic               frame_err_o,
    output logic               overrun_o
);

    localparam int               CNT_W     = bit_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      sync1_q;
    logic                      sync2_q;
    logic                      prev_q;
    rx_state_e                 state_q;
    rx_state_e                 state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [2:0]                bit_q;
    logic [2:0]                bit_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic                      frame_err_q;
    logic                      frame_err_d;
    logic                      overrun_q;
    logic                      push_s;
    logic                      drop_s;
    logic                      empty_s;

    // Synchronizer and edge register; loaded with the idle level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver FSM state, bit timing and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_q       <= 3'd0;
            shift_q     <= {UART_DATA_BITS{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= drop_s;
        end
    end

    // Next-state logic. The START phase counts half a bit so that all later
    // samples, spaced a full bit apart, land near the bit centres.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = {CNT_W{1'b0}};
                    bit_d = 3'd0;
                    // A line already high again at mid start bit was a glitch.
                    if (!sync2_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (sync2_q) begin
                        push_s  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_BREAK;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_BREAK: begin
                cnt_d = {CNT_W{1'b0}};
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_BREAK;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    uart_rx_capture_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .data_i  (shift_q),
        .pop_i   (rd_en_i),
        .data_o  (rd_data_o),
        .empty_o (empty_s),
        .count_o (fifo_count_o),
        .drop_o  (drop_s)
    );

    assign rd_valid_o  = ~empty_s;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
`timescale 1ns/1ps
module tb_uart_rx_capture;

    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    // Frame cycle (counted from the start-bit fall) whose following edge is
    // the stop-bit sample: 3 cycles of synchronizer/edge detect, half a bit,
    // then 9 full bits, minus one because rd_en is set a cycle ahead.
    localparam int STOP_POP_C = 3 + CPB / 2 + 9 * CPB - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_rx;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] model_q [$];

    uart_rx_capture #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_i    (uart_rx),
        .rd_en_i      (rd_en),
        .rd_data_o    (rd_data),
        .rd_valid_o   (rd_valid),
        .fifo_count_o (fifo_count),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
        if (frame_err === 1'b1 && overrun === 1'b1) begin
            errors++;
            $display("FAIL pulse_overlap: frame_err and overrun both 1 at %0t", $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: a received byte joins the queue unless it is full.
    task automatic model_push(input logic [7:0] b);
        if (model_q.size() == DEPTH) exp_ov++;
        else model_q.push_back(b);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    // Drive one 8N1 frame. stop_low>0 holds the stop bit low that many clocks.
    task automatic send_frame(input logic [7:0] data, input int stop_low, input bit pop_at_stop);
        int len;
        len = 144 + ((stop_low > 0) ? stop_low : 16);
        for (int c = 0; c < len; c++) begin
            if (c < 16) uart_rx = 1'b0;
            else if (c < 144) uart_rx = data[(c - 16) / 16];
            else uart_rx = (stop_low > 0) ? 1'b0 : 1'b1;
            rd_en = (pop_at_stop && c == STOP_POP_C) ? 1'b1 : 1'b0;
            tick(1);
        end
        uart_rx = 1'b1;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(1);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rd_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", rd_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got fe=%0b ov=%0b expected 0", frame_err, overrun); end
    endtask

    task automatic test_two_bytes();
        send_frame(8'h55, 0, 1'b0); model_push(8'h55);
        send_frame(8'hA3, 0, 1'b0); model_push(8'hA3);
        tick(4);
        for (int i = 0; i < 2; i++) begin
            checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("FAIL two_count%0d: got %0d expected %0d", i, fifo_count, model_q.size()); end
            checks++; if (rd_data !== model_q[0] || rd_valid !== 1'b1) begin errors++; $display("FAIL two_data%0d: got %0h v=%0b expected %0h", i, rd_data, rd_valid, model_q[0]); end
            pop_one(); void'(model_q.pop_front());
        end
        checks++; if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL two_empty: got count %0d v=%0b expected 0", fifo_count, rd_valid); end
        checks++; if (fe_seen !== exp_fe || ov_seen !== exp_ov) begin errors++; $display("FAIL two_pulses: got fe=%0d ov=%0d expected %0d %0d", fe_seen, ov_seen, exp_fe, exp_ov); end
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0; tick(4);
        uart_rx = 1'b1; tick(200);
        checks++; if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL glitch_byte: got count %0d expected 0", fifo_count); end
        checks++; if (fe_seen !== exp_fe || ov_seen !== exp_ov) begin errors++; $display("FAIL glitch_pulses: got fe=%0d ov=%0d expected %0d %0d", fe_seen, ov_seen, exp_fe, exp_ov); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 40, 1'b0); exp_fe++;
        tick(20);
        checks++; if (fe_seen !== exp_fe) begin errors++; $display("FAIL ferr_pulse: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ferr_count: got %0d expected 0", fifo_count); end
        send_frame(8'h7E, 0, 1'b0); model_push(8'h7E);
        tick(4);
        checks++; if (fifo_count !== 3'(model_q.size()) || rd_data !== model_q[0]) begin errors++; $display("FAIL ferr_next: got %0h count %0d expected %0h", rd_data, fifo_count, model_q[0]); end
        pop_one(); void'(model_q.pop_front());
        checks++; if (fe_seen !== exp_fe || ov_seen !== exp_ov) begin errors++; $display("FAIL ferr_pulses: got fe=%0d ov=%0d expected %0d %0d", fe_seen, ov_seen, exp_fe, exp_ov); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 6; i++) begin
            send_frame(8'(i), 0, 1'b0); model_push(8'(i));
        end
        tick(4);
        checks++; if (ov_seen !== exp_ov) begin errors++; $display("FAIL ovr_pulses: got %0d expected %0d", ov_seen, exp_ov); end
        checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", fifo_count, model_q.size()); end
        while (model_q.size() > 0) begin
            checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL ovr_data: got %0h expected %0h", rd_data, model_q[0]); end
            pop_one(); void'(model_q.pop_front());
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got v=%0b expected 0", rd_valid); end
    endtask

    task automatic test_pop_at_full();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 0, 1'b0); model_push(b);
        end
        tick(4);
        checks++; if (fifo_count !== 3'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", fifo_count, DEPTH); end
        send_frame(8'h99, 0, 1'b1);
        void'(model_q.pop_front()); model_push(8'h99);
        tick(4);
        checks++; if (ov_seen !== exp_ov) begin errors++; $display("FAIL full_noovr: got %0d expected %0d", ov_seen, exp_ov); end
        checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("FAIL full_count2: got %0d expected %0d", fifo_count, model_q.size()); end
        while (model_q.size() > 0) begin
            checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL full_data: got %0h expected %0h", rd_data, model_q[0]); end
            pop_one(); void'(model_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h5A, 0, 1'b0); model_push(8'h5A);
        tick(4);
        // Start bit plus bits 0..2 and half of bit 3 of a frame, then reset.
        for (int c = 0; c < 16 + 3 * 16 + 8; c++) begin
            uart_rx = (c < 16) ? 1'b0 : ((c % 32) < 16 ? 1'b1 : 1'b0);
            tick(1);
        end
        rst = 1'b1; uart_rx = 1'b1;
        tick(1);
        rst = 1'b0;
        model_q.delete();
        checks++; if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_count: got %0d v=%0b expected 0", fifo_count, rd_valid); end
        checks++; if (rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_outs: got d=%0h fe=%0b ov=%0b expected 0", rd_data, frame_err, overrun); end
        tick(200);
        checks++; if (fifo_count !== 3'd0 || fe_seen !== exp_fe || ov_seen !== exp_ov) begin errors++; $display("FAIL rstmid_quiet: got count %0d fe=%0d ov=%0d expected 0 %0d %0d", fifo_count, fe_seen, ov_seen, exp_fe, exp_ov); end
        send_frame(8'hC5, 0, 1'b0); model_push(8'hC5);
        tick(4);
        checks++; if (fifo_count !== 3'd1 || rd_data !== model_q[0]) begin errors++; $display("FAIL rstmid_next: got %0h count %0d expected %0h", rd_data, fifo_count, model_q[0]); end
        pop_one(); void'(model_q.pop_front());
    endtask

    task automatic test_random();
        for (int it = 0; it < 14; it++) begin
            int npops;
            logic [7:0] b;
            npops = $urandom_range(0, 2);
            for (int p = 0; p < npops; p++) begin
                if (model_q.size() > 0) begin
                    checks++; if (rd_data !== model_q[0] || rd_valid !== 1'b1) begin errors++; $display("FAIL rand_pop%0d: got %0h v=%0b expected %0h", it, rd_data, rd_valid, model_q[0]); end
                    void'(model_q.pop_front());
                end else begin
                    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rand_emptypop%0d: got v=%0b expected 0", it, rd_valid); end
                end
                pop_one();
            end
            b = 8'($urandom);
            send_frame(b, 0, 1'b0); model_push(b);
            tick(6);
            checks++; if (fifo_count !== 3'(model_q.size())) begin errors++; $display("FAIL rand_count%0d: got %0d expected %0d", it, fifo_count, model_q.size()); end
            checks++; if (ov_seen !== exp_ov || fe_seen !== exp_fe) begin errors++; $display("FAIL rand_pulses%0d: got ov=%0d fe=%0d expected %0d %0d", it, ov_seen, fe_seen, exp_ov, exp_fe); end
        end
        while (model_q.size() > 0) begin
            checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL rand_drain: got %0h expected %0h", rd_data, model_q[0]); end
            pop_one(); void'(model_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_pop_at_full();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
